// File: rtl/spiflash_emu_if.sv
// SPI/QSPI flash pin bundle plus backdoor preload port.
//   sck, csb, io_in      : SPI pins driven by the master (the SoC under test)
//   io_out, io_oe        : per-pin data and output enable driven by the flash
//   bd_we/addr/wdata     : backdoor byte write into the flash array
//   busy                 : mirrors the status WIP bit
// The master modport is the SoC/bench side; slave is the flash emulator.
interface spiflash_emu_if #(
  parameter int unsigned MEM_AW = 12
) ();
  logic              sck;
  logic              csb;
  logic [3:0]        io_in;
  logic [3:0]        io_out;
  logic [3:0]        io_oe;
  logic              bd_we;
  logic [MEM_AW-1:0] bd_addr;
  logic [7:0]        bd_wdata;
  logic              busy;

  modport master (
    output sck, csb, io_in, bd_we, bd_addr, bd_wdata,
    input  io_out, io_oe, busy
  );

  modport slave (
    input  sck, csb, io_in, bd_we, bd_addr, bd_wdata,
    output io_out, io_oe, busy
  );
endinterface

// File: rtl/spiflash_emu.sv
// Oversampling SPI/QSPI flash emulator. The SPI pins are synchronised into the
// clk domain (clk must run at least 8x sck). Serves 03/0B/EB reads, 05 status,
// 06/04 write-enable, 02 page program, B9/AB power-down and FF xip exit from an
// internal 2**MEM_AW byte array that can also be preloaded through a backdoor.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi_if     : flash pins, backdoor port and busy (slave modport)
// SYNC_STAGES must be at least 2 and MEM_AW at least 5.
module spiflash_emu #(
  parameter int unsigned ADDR_BYTES   = 3,
  parameter int unsigned MEM_AW       = 12,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter int unsigned PAGE_AW      = 8,
  parameter int unsigned PROG_CYCLES  = 64,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input logic             clk,
  input logic             rst_n,
  spiflash_emu_if.slave   spi_if
);

  localparam logic [7:0] OpProg    = 8'h02;
  localparam logic [7:0] OpRead    = 8'h03;
  localparam logic [7:0] OpWrdi    = 8'h04;
  localparam logic [7:0] OpRdsr    = 8'h05;
  localparam logic [7:0] OpWren    = 8'h06;
  localparam logic [7:0] OpFast    = 8'h0B;
  localparam logic [7:0] OpRes     = 8'hAB;
  localparam logic [7:0] OpDp      = 8'hB9;
  localparam logic [7:0] OpQread   = 8'hEB;
  localparam logic [7:0] OpXipExit = 8'hFF;

  localparam logic [7:0] AddrLastS = 8'(ADDR_BYTES * 8 - 1);
  localparam logic [7:0] AddrLastQ = 8'(ADDR_BYTES * 2 - 1);
  localparam logic [7:0] DummyLast = 8'(DUMMY_CYCLES - 1);
  localparam int unsigned WipW     = $clog2(PROG_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StMode, StDummy, StDout, StDin, StIgnore
  } state_e;

  // Pin synchronisers
  logic [SYNC_STAGES-1:0]      sck_sync_q, csb_sync_q;
  logic [SYNC_STAGES-1:0][3:0] io_sync_q;
  logic                        sck_prev_q, csb_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      csb_sync_q <= '1;
      io_sync_q  <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_if.sck};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_if.csb};
      io_sync_q  <= {io_sync_q[SYNC_STAGES-2:0], spi_if.io_in};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      csb_prev_q <= csb_sync_q[SYNC_STAGES-1];
    end
  end

  logic       sck_s, csb_s;
  logic [3:0] io_s;
  logic       sck_rise, sck_fall, csb_rise, csb_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign io_s     = io_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csb_rise = csb_s & ~csb_prev_q;
  assign csb_fall = ~csb_s & csb_prev_q;

  // Protocol state
  state_e            state_q, cmd_state;
  logic [7:0]        cnt_q;
  logic [6:0]        rx_sr_q;
  logic [7:0]        tx_sr_q;
  logic [MEM_AW-1:0] addr_q;
  logic [7:0]        op_q;
  logic              quad_q, wel_q, wip_q, pd_q, xip_q, prog_byte_q;
  logic [WipW-1:0]   wip_cnt_q;
  logic [3:0]        io_out_q, io_oe_q;

  logic [7:0]        mem_q [2**MEM_AW];
  logic [7:0]        rx_byte, mode_byte, load_byte, tx_byte;
  logic [MEM_AW-1:0] addr_shift;
  logic [7:0]        addr_last;
  logic              prog_we, bd_we_ok;

  assign rx_byte    = {rx_sr_q, io_s[0]};
  assign mode_byte  = {rx_sr_q[3:0], io_s};
  assign addr_shift = quad_q ? {addr_q[MEM_AW-5:0], io_s} : {addr_q[MEM_AW-2:0], io_s[0]};
  assign addr_last  = quad_q ? AddrLastQ : AddrLastS;
  // Status is sampled afresh at every byte boundary so RDSR tracks WIP live.
  assign load_byte  = (op_q == OpRdsr) ? {6'b0, wel_q, wip_q} : mem_q[addr_q];
  assign tx_byte    = (cnt_q == 8'd0) ? load_byte : tx_sr_q;
  assign prog_we    = (state_q == StDin) && sck_rise && !csb_rise && (cnt_q == 8'd7);
  assign bd_we_ok   = spi_if.bd_we && csb_s;

  // Opcode gating: power-down admits only AB (which ends the command), WIP admits only 05.
  always_comb begin
    cmd_state = StIgnore;
    if (!pd_q) begin
      if (wip_q) begin
        if (rx_byte == OpRdsr) cmd_state = StDout;
      end else begin
        case (rx_byte)
          OpRead, OpFast, OpQread: cmd_state = StAddr;
          OpProg:                  cmd_state = wel_q ? StAddr : StIgnore;
          OpRdsr:                  cmd_state = StDout;
          default:                 cmd_state = StIgnore;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[addr_q] <= rx_byte;
    end else if (bd_we_ok) begin
      mem_q[spi_if.bd_addr] <= spi_if.bd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      addr_q      <= '0;
      op_q        <= '0;
      quad_q      <= 1'b0;
      wel_q       <= 1'b0;
      wip_q       <= 1'b0;
      pd_q        <= 1'b0;
      xip_q       <= 1'b0;
      prog_byte_q <= 1'b0;
      wip_cnt_q   <= '0;
      io_out_q    <= '0;
      io_oe_q     <= '0;
    end else begin
      if (wip_cnt_q != '0) begin
        wip_cnt_q <= wip_cnt_q - WipW'(1);
        if (wip_cnt_q == WipW'(1)) wip_q <= 1'b0;
      end

      if (csb_rise) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        io_out_q    <= '0;
        io_oe_q     <= '0;
        prog_byte_q <= 1'b0;
        if (state_q == StDin && prog_byte_q) begin
          wip_q     <= 1'b1;
          wel_q     <= 1'b0;
          wip_cnt_q <= WipW'(PROG_CYCLES);
        end
      end else if (csb_fall) begin
        cnt_q       <= '0;
        rx_sr_q     <= '0;
        prog_byte_q <= 1'b0;
        if (xip_q) begin
          // Continuous-read mode: opcode is implied, address follows at once.
          state_q <= StAddr;
          op_q    <= OpQread;
          quad_q  <= 1'b1;
        end else begin
          state_q <= StCmd;
          quad_q  <= 1'b0;
        end
      end else if (sck_rise) begin
        unique case (state_q)
          StCmd: begin
            rx_sr_q <= rx_byte[6:0];
            if (cnt_q == 8'd7) begin
              cnt_q   <= '0;
              op_q    <= rx_byte;
              state_q <= cmd_state;
              if (pd_q) begin
                if (rx_byte == OpRes) pd_q <= 1'b0;
              end else if (!wip_q) begin
                case (rx_byte)
                  OpWren:    wel_q  <= 1'b1;
                  OpWrdi:    wel_q  <= 1'b0;
                  OpDp:      pd_q   <= 1'b1;
                  OpXipExit: xip_q  <= 1'b0;
                  OpQread:   quad_q <= 1'b1;
                  default: ;
                endcase
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StAddr: begin
            addr_q <= addr_shift;
            if (cnt_q == addr_last) begin
              cnt_q <= '0;
              case (op_q)
                OpRead:  state_q <= StDout;
                OpFast:  state_q <= (DUMMY_CYCLES == 0) ? StDout : StDummy;
                OpQread: state_q <= StMode;
                OpProg:  state_q <= StDin;
                default: state_q <= StIgnore;
              endcase
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StMode: begin
            rx_sr_q <= mode_byte[6:0];
            if (cnt_q == 8'd1) begin
              cnt_q   <= '0;
              xip_q   <= (mode_byte == 8'hA5);
              state_q <= (DUMMY_CYCLES == 0) ? StDout : StDummy;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StDummy: begin
            if (cnt_q == DummyLast) begin
              cnt_q   <= '0;
              state_q <= StDout;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StDin: begin
            rx_sr_q <= rx_byte[6:0];
            if (cnt_q == 8'd7) begin
              cnt_q                <= '0;
              prog_byte_q          <= 1'b1;
              addr_q[PAGE_AW-1:0]  <= addr_q[PAGE_AW-1:0] + PAGE_AW'(1);
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          StIdle, StDout, StIgnore: ;
        endcase
      end else if (sck_fall && state_q == StDout) begin
        if (cnt_q == 8'd0 && op_q != OpRdsr) addr_q <= addr_q + MEM_AW'(1);
        if (quad_q) begin
          io_out_q <= tx_byte[7:4];
          io_oe_q  <= 4'b1111;
          tx_sr_q  <= {tx_byte[3:0], 4'b0000};
          cnt_q    <= (cnt_q == 8'd1) ? 8'd0 : cnt_q + 8'd1;
        end else begin
          io_out_q <= {2'b00, tx_byte[7], 1'b0};
          io_oe_q  <= 4'b0010;
          tx_sr_q  <= {tx_byte[6:0], 1'b0};
          cnt_q    <= (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
        end
      end
    end
  end

  assign spi_if.io_out = io_out_q;
  assign spi_if.io_oe  = io_oe_q;
  assign spi_if.busy   = wip_q;

endmodule
